// File: rtl/nibble_adder_pkg.sv
// Shared types and helpers for the nibble-serial adder sequencer.
// Optional subtract mode is enabled by NIBBLE_SERIAL_ADDER_SUB_EN.
package nibble_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nibble_serial_adder.sv
// Adds two W-bit operands one nibble per clock through an external 4-bit adder.
// Define NIBBLE_SERIAL_ADDER_SUB_EN to add the sub port (A - B mode).
module nibble_serial_adder
    import nibble_adder_pkg::*;
#(
    parameter int NIBBLES = 4,
    localparam int W = NIBBLE_W * NIBBLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [W-1:0]        op_a,
    input  logic [W-1:0]        op_b,
    input  logic                cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    input  logic                sub,
`endif
    output logic                busy,
    output logic                done,
    output logic [W-1:0]        sum,
    output logic                cout,
    output logic [NIBBLE_W-1:0] add_a,
    output logic [NIBBLE_W-1:0] add_b,
    output logic                add_cin,
    input  logic [NIBBLE_W-1:0] add_s,
    input  logic                add_cout
);

    localparam int IW = idx_width(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  work_q, work_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = op_a;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
                    // Two's complement: invert B and force carry-in high.
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub ? 1'b1 : cin;
`else
                    b_d     = op_b;
                    carry_d = cin;
`endif
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                add_a   = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
                add_b   = b_q[NIBBLE_W*idx_q +: NIBBLE_W];
                add_cin = carry_q;
                work_d[NIBBLE_W*idx_q +: NIBBLE_W] = add_s;
                carry_d = add_cout;
                if (idx_q == LAST) begin
                    sum_d   = work_d;
                    cout_d  = add_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder with a behavioural 4-bit adder.
// Subtract cases run only when NIBBLE_SERIAL_ADDER_SUB_EN is defined.
module tb_nibble_serial_adder;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         busy, done, cout, add_cin, add_cout;
    logic [W-1:0] sum;
    logic [3:0]   add_a, add_b, add_s;

    int n_tests = 0;
    int n_fail  = 0;
    int n_push  = 0;
    int n_done  = 0;
    logic [W:0] exp_q[$];
    logic       cins[8];

    always #5 clk = ~clk;

    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic c, input logic s);
        logic [W-1:0] bb;
        logic         cc;
        bb = s ? ~b : b;
        cc = s ? 1'b1 : c;
        return {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
    endfunction

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s);
        exp_q.push_back(model(a, b, c, s));
        n_push++;
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            logic [W:0] e;
            n_done++;
            if (exp_q.size() == 0) begin
                chk("extra_done", 64'(done), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sum", 64'(sum), 64'(e[W-1:0]));
                chk("cout", 64'(cout), 64'(e[W]));
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic s, input string tag);
        int  edges;
        bit  got;
        @(negedge clk);
        op_a = a; op_b = b; cin = c; sub = s; start = 1'b1;
        push(a, b, c, s);
        @(posedge clk);
        #1 start = 1'b0;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        edges = 1;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
            if (k < 8) cins[k] = add_cin;
            edges++;
        end
        chk({tag, "_done_seen"}, 64'(got), 64'd1);
        // Start edge plus one edge per nibble.
        chk({tag, "_latency"}, 64'(edges), 64'(N + 1));
        @(posedge clk);
        #1 chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic wait_done(input string tag);
        bit got;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 64'(got), 64'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_adder", 64'({add_a, add_b, add_cin}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, "basic");
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "ripple");
        for (int k = 1; k < N; k++)
            chk("ripple_cin", 64'(cins[k]), 64'd1);
        chk("ripple_cin0", 64'(cins[0]), 64'd0);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0, "cin_only");
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "cin_ff");

        // start held high across the whole operation
        @(negedge clk);
        op_a = 16'h1111; op_b = 16'h2222; cin = 1'b0; sub = 1'b0;
        start = 1'b1;
        push(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        op_a = 16'hAAAA;
        op_b = 16'h5555;
        wait_done("hold1");
        op_a = 16'h0F0F;
        op_b = 16'h0101;
        @(negedge clk);
        chk("hold_idle", 64'(busy), 64'd0);
        push(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        chk("hold2_busy", 64'(busy), 64'd1);
        wait_done("hold2");
        @(posedge clk);

        // asynchronous reset in the middle of nibble 2
        @(negedge clk);
        op_a = 16'h5678; op_b = 16'h1111; cin = 1'b0; start = 1'b1;
        push(16'h5678, 16'h1111, 1'b0, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_sum", 64'(sum), 64'd0);
        chk("abort_cout", 64'(cout), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_adder", 64'({add_a, add_b, add_cin}), 64'd0);
        repeat (2) @(negedge clk);
        chk("abort_done2", 64'(done), 64'd0);
        chk("abort_pending", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_back());
            n_push--;
        end
        rst_n = 1'b1;
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, "post_rst");

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, "sub_borrow");
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, "sub_noborrow");
        run_op(16'h0007, 16'h0005, 1'b1, 1'b0, "sub_off");
`endif

        repeat (3) @(negedge clk);
        chk("done_count", 64'(n_done), 64'(n_push));
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
